// File: rtl/wb_dbg_bridge.sv
// ============================================================================
// Module  : wb_dbg_bridge
// Brief   : UART-style byte command bridge to a 32-bit Wishbone master.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_dbg_bridge #(
  parameter int unsigned bus_timeout = 1024,
  parameter int unsigned rx_timeout  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_ADDR   = 3'd1;
  localparam logic [2:0] C_DATA   = 3'd2;
  localparam logic [2:0] C_BUS    = 3'd3;
  localparam logic [2:0] C_RESP   = 3'd4;
  localparam logic [2:0] C_TXWAIT = 3'd5;

  localparam logic [7:0] C_CMD_W = 8'h57;
  localparam logic [7:0] C_CMD_R = 8'h52;
  localparam logic [7:0] C_ACK   = 8'h06;
  localparam logic [7:0] C_NAK   = 8'h15;

  localparam int unsigned RXW = $clog2(rx_timeout + 1);
  localparam int unsigned BTW = $clog2(bus_timeout + 1);

  logic [2:0]     state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [RXW-1:0] idle_q, idle_d;
  logic [BTW-1:0] bto_q, bto_d;
  logic           cyc_q, cyc_d;
  logic [31:0]    resp_q, resp_d;
  logic [1:0]     rem_q, rem_d;
  logic           first_q, first_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_wr_q, tx_wr_d;

  // State register: async reset drops cyc/stb without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= C_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      idle_q    <= '0;
      bto_q     <= '0;
      cyc_q     <= 1'b0;
      resp_q    <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      idle_q    <= idle_d;
      bto_q     <= bto_d;
      cyc_q     <= cyc_d;
      resp_q    <= resp_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    idle_d    = idle_q;
    bto_d     = bto_q;
    cyc_d     = cyc_q;
    resp_d    = resp_q;
    rem_d     = rem_q;
    first_d   = 1'b0;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;

    case (state_q)
      C_IDLE: begin
        if (rx_valid && (rx_data == C_CMD_W || rx_data == C_CMD_R)) begin
          state_d = C_ADDR;
          we_d    = (rx_data == C_CMD_W);
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      C_ADDR: begin
        if (rx_valid) begin
          adr_d  = {adr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          idle_d = '0;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = C_DATA;
              cnt_d   = '0;
            end else begin
              state_d = C_BUS;
              cyc_d   = 1'b1;
              bto_d   = '0;
            end
          end
        end else if (idle_q == RXW'(rx_timeout - 1)) begin
          state_d = C_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      C_DATA: begin
        if (rx_valid) begin
          dat_d  = {dat_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          idle_d = '0;
          if (cnt_q == 2'd3) begin
            state_d = C_BUS;
            cyc_d   = 1'b1;
            bto_d   = '0;
          end
        end else if (idle_q == RXW'(rx_timeout - 1)) begin
          state_d = C_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      C_BUS: begin
        // err wins over ack when both arrive together.
        if (wb_ack_i || wb_err_i) begin
          cyc_d   = 1'b0;
          state_d = C_RESP;
          if (wb_err_i) begin
            resp_d = {C_NAK, 24'h0};
            rem_d  = 2'd0;
          end else if (we_q) begin
            resp_d = {C_ACK, 24'h0};
            rem_d  = 2'd0;
          end else begin
            resp_d = wb_dat_i;
            rem_d  = 2'd3;
          end
        end else if (bto_q == BTW'(bus_timeout - 1)) begin
          cyc_d   = 1'b0;
          state_d = C_RESP;
          resp_d  = {C_NAK, 24'h0};
          rem_d   = 2'd0;
        end else begin
          bto_d = bto_q + 1'b1;
        end
      end
      C_RESP: begin
        if (!tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = resp_q[31:24];
          resp_d    = {resp_q[23:0], 8'h0};
          first_d   = 1'b1;
          state_d   = C_TXWAIT;
        end
      end
      C_TXWAIT: begin
        // The first TXWAIT cycle gives the transmitter time to raise busy.
        if (!first_q && !tx_busy) begin
          if (rem_q != 2'd0) begin
            rem_d   = rem_q - 2'd1;
            state_d = C_RESP;
          end else begin
            state_d = C_IDLE;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    wb_adr_o = adr_q;
    wb_dat_o = dat_q;
    wb_sel_o = 4'hF;
    wb_we_o  = we_q;
    wb_cyc_o = cyc_q;
    wb_stb_o = cyc_q;
    tx_data  = tx_data_q;
    tx_wr    = tx_wr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_dbg_bridge.sv
// ============================================================================
// Module  : tb_wb_dbg_bridge
// Brief   : Self-checking bench for wb_dbg_bridge (command-level model).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_dbg_bridge;

  localparam int BTO = 16;
  localparam int RXT = 64;
  localparam int TXB = 5;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_BOTH = 3;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  wb_dbg_bridge #(.bus_timeout(BTO), .rx_timeout(RXT)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected and observed transactions.
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  bus_t        obs_bus[$];
  int          obs_len[$];
  logic [7:0]  obs_tx[$];

  // Command parser state of the model.
  logic [7:0]  mbuf [0:8];
  int          mn = 0;

  // Slave behaviour for the next command.
  int          slv_mode  = M_ACK;
  int          slv_delay = 0;
  logic [31:0] slv_rdata = 32'h0;

  // Compare process state.
  logic        cyc_prev = 1'b0;
  int          bus_len  = 0;
  bus_t        cur;
  logic [31:0] start_dat = 32'h0;
  logic [7:0]  last_tx  = 8'h0;
  int          busy_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Command-level model: rebuilds commands from the byte stream and predicts
  // the bus cycle and the reply bytes.
  task automatic model_byte(input logic [7:0] b, input int gap);
    bus_t e;
    if (mn > 0 && gap >= RXT) mn = 0;
    if (mn == 0) begin
      if (b == 8'h57 || b == 8'h52) begin
        mbuf[0] = b;
        mn = 1;
      end
    end else begin
      mbuf[mn] = b;
      mn++;
      if ((mbuf[0] == 8'h57 && mn == 9) || (mbuf[0] == 8'h52 && mn == 5)) begin
        e.we  = (mbuf[0] == 8'h57);
        e.adr = {mbuf[1], mbuf[2], mbuf[3], mbuf[4]};
        e.dat = e.we ? {mbuf[5], mbuf[6], mbuf[7], mbuf[8]} : 32'h0;
        e.len = (slv_mode == M_NONE) ? BTO : slv_delay + 1;
        exp_bus.push_back(e);
        if (slv_mode != M_ACK) exp_tx.push_back(8'h15);
        else if (e.we) exp_tx.push_back(8'h06);
        else for (int i = 3; i >= 0; i--) exp_tx.push_back(slv_rdata[8*i +: 8]);
        mn = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit modeled);
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (modeled) model_byte(b, gap);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                          input int gidx, input int gap);
    logic [7:0] b [0:8];
    int n;
    b[0] = c;
    b[1] = a[31:24]; b[2] = a[23:16]; b[3] = a[15:8]; b[4] = a[7:0];
    b[5] = d[31:24]; b[6] = d[23:16]; b[7] = d[15:8]; b[8] = d[7:0];
    n = (c == 8'h57) ? 9 : 5;
    for (int i = 0; i < n; i++) send_byte(b[i], (i == gidx) ? gap : 0, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || wb_cyc_o || tx_busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, 32'(n < 3000), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string name);
    int n;
    n = 0;
    while (!wb_cyc_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_cyc_seen"}, 32'(wb_cyc_o), 32'd1);
  endtask

  // Pins the observed traffic of one test to hand-computed literals.
  task automatic pin(input string name, input int nbus, input logic [31:0] adr, input logic we,
                     input logic [31:0] dat, input int len, input int ntx, input logic [31:0] txw);
    check({name, "_nbus"}, obs_bus.size(), nbus);
    if (obs_bus.size() > 0) begin
      check({name, "_adr"}, obs_bus[0].adr, adr);
      check({name, "_we"}, 32'(obs_bus[0].we), 32'(we));
      if (we) check({name, "_dat"}, obs_bus[0].dat, dat);
    end
    if (len >= 0) check({name, "_len"}, (obs_len.size() > 0) ? obs_len[0] : -1, len);
    check({name, "_ntx"}, obs_tx.size(), ntx);
    for (int i = 0; i < ntx && i < obs_tx.size(); i++)
      check({name, "_txbyte"}, obs_tx[i], txw[31-8*i -: 8]);
    obs_bus.delete();
    obs_len.delete();
    obs_tx.delete();
  endtask

  // Wishbone slave: answers per slv_mode after slv_delay cycles of cyc.
  initial begin : slave
    int scnt;
    scnt     = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'hBAD0_BAD0;
      if (wb_cyc_o && wb_stb_o && !reset) begin
        if (scnt == slv_delay && slv_mode != M_NONE) begin
          wb_ack_i = (slv_mode == M_ACK || slv_mode == M_BOTH);
          wb_err_i = (slv_mode == M_ERR || slv_mode == M_BOTH);
          if (wb_ack_i) wb_dat_i = slv_rdata;
        end
        scnt++;
      end else begin
        scnt = 0;
      end
    end
  end

  // Compare process, plus the transmitter model that drives tx_busy.
  initial begin : compare
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, tx_wr}, 32'h0);
        check("rst_txdata", tx_data, 32'h0);
        check("rst_sel", wb_sel_o, 32'hF);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        cyc_prev = 1'b0;
        last_tx  = 8'h0;
      end else begin
        check("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
        check("sel", wb_sel_o, 32'hF);
        if (wb_cyc_o && !cyc_prev) begin
          bus_t o;
          check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
          if (exp_bus.size() != 0) begin
            cur = exp_bus.pop_front();
            check("bus_adr", wb_adr_o, cur.adr);
            check("bus_we", 32'(wb_we_o), 32'(cur.we));
            if (cur.we) check("bus_dat", wb_dat_o, cur.dat);
          end else begin
            cur.adr = wb_adr_o;
            cur.dat = wb_dat_o;
            cur.we  = wb_we_o;
            cur.len = -1;
          end
          o.adr = wb_adr_o;
          o.dat = wb_dat_o;
          o.we  = wb_we_o;
          o.len = 0;
          obs_bus.push_back(o);
          start_dat = wb_dat_o;
          bus_len   = 0;
        end
        if (wb_cyc_o) begin
          bus_len++;
          check("adr_hold", wb_adr_o, cur.adr);
          check("dat_hold", wb_dat_o, start_dat);
          check("we_hold", 32'(wb_we_o), 32'(cur.we));
        end
        if (!wb_cyc_o && cyc_prev) begin
          check("bus_len", bus_len, cur.len);
          obs_len.push_back(bus_len);
        end
        cyc_prev = wb_cyc_o;
        if (tx_wr) begin
          check("tx_while_busy", 32'(tx_busy), 32'd0);
          check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
          if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
          obs_tx.push_back(tx_data);
          last_tx = tx_data;
        end else begin
          check("tx_hold", tx_data, last_tx);
        end
      end
      if (tx_wr && !reset) busy_cnt = TXB;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
  end

  initial begin : stim
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc_init", 32'(wb_cyc_o), 32'd0);
    check("rst_sel_init", wb_sel_o, 32'hF);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write with ack after 2 cycles.
    slv_mode = M_ACK; slv_delay = 2; slv_rdata = 32'h0;
    send_cmd(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, -1, 0);
    wait_done("wr");
    pin("wr", 1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 3, 1, 32'h0600_0000);

    // Read returning four bytes MSB first.
    slv_mode = M_ACK; slv_delay = 1; slv_rdata = 32'h1234_5678;
    send_cmd(8'h52, 32'h7000_0004, 32'h0, -1, 0);
    wait_done("rd");
    pin("rd", 1, 32'h7000_0004, 1'b0, 32'h0, 2, 4, 32'h1234_5678);

    // Read with no slave answer: bus timeout.
    slv_mode = M_NONE; slv_delay = 0;
    send_cmd(8'h52, 32'h5000_0000, 32'h0, -1, 0);
    wait_done("bto");
    pin("bto", 1, 32'h5000_0000, 1'b0, 32'h0, BTO, 1, 32'h1500_0000);

    // Write answered by err.
    slv_mode = M_ERR; slv_delay = 0;
    send_cmd(8'h57, 32'h0000_2000, 32'h0BAD_F00D, -1, 0);
    wait_done("werr");
    pin("werr", 1, 32'h0000_2000, 1'b1, 32'h0BAD_F00D, 1, 1, 32'h1500_0000);

    // Read with ack and err together.
    slv_mode = M_BOTH; slv_delay = 3; slv_rdata = 32'hFFFF_FFFF;
    send_cmd(8'h52, 32'h3000_0008, 32'h0, -1, 0);
    wait_done("both");
    pin("both", 1, 32'h3000_0008, 1'b0, 32'h0, 4, 1, 32'h1500_0000);

    // Partial write discarded after rx_timeout idle cycles; read follows.
    slv_mode = M_ACK; slv_delay = 0; slv_rdata = 32'hCAFE_F00D;
    send_byte(8'h57, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_cmd(8'h52, 32'h0000_0000, 32'h0, 0, RXT);
    wait_done("rxto");
    pin("rxto", 1, 32'h0000_0000, 1'b0, 32'h0, 1, 4, 32'hCAFE_F00D);

    // Gap one short of the timeout keeps the command alive.
    slv_mode = M_ACK; slv_delay = 0;
    send_cmd(8'h57, 32'h1122_3344, 32'h5566_7788, 5, RXT - 1);
    wait_done("gapok");
    pin("gapok", 1, 32'h1122_3344, 1'b1, 32'h5566_7788, 1, 1, 32'h0600_0000);

    // Junk bytes in IDLE are ignored.
    slv_mode = M_ACK; slv_delay = 0; slv_rdata = 32'h0000_00FF;
    send_byte(8'h41, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h06, 0, 1'b1);
    send_byte(8'h15, 0, 1'b1);
    send_cmd(8'h52, 32'h0000_0010, 32'h0, -1, 0);
    wait_done("junk");
    pin("junk", 1, 32'h0000_0010, 1'b0, 32'h0, 1, 4, 32'h0000_00FF);

    // Bytes arriving during BUS are dropped.
    slv_mode = M_ACK; slv_delay = 6; slv_rdata = 32'hA5A5_0F0F;
    send_cmd(8'h52, 32'h0000_0040, 32'h0, -1, 0);
    wait_cyc("inj");
    send_byte(8'h57, 0, 1'b0);
    send_byte(8'h52, 0, 1'b0);
    wait_done("inj");
    pin("inj", 1, 32'h0000_0040, 1'b0, 32'h0, 7, 4, 32'hA5A5_0F0F);

    // Reset in the middle of a stalled read.
    slv_mode = M_NONE; slv_delay = 0;
    send_byte(8'h41, 0, 1'b1);
    send_cmd(8'h52, 32'h0000_0100, 32'h0, -1, 0);
    wait_cyc("rstmid");
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    exp_tx.delete();
    mn = 0;
    #1;
    check("rstmid_cyc_async", {wb_cyc_o, wb_stb_o}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    pin("rstmid", 1, 32'h0000_0100, 1'b0, 32'h0, -1, 0, 32'h0);

    slv_mode = M_ACK; slv_delay = 1;
    send_cmd(8'h57, 32'h0000_0200, 32'h0102_0304, -1, 0);
    wait_done("after_rst");
    pin("after_rst", 1, 32'h0000_0200, 1'b1, 32'h0102_0304, 2, 1, 32'h0600_0000);

    check("end_exp_bus_empty", exp_bus.size(), 32'd0);
    check("end_exp_tx_empty", exp_tx.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_dbg_bridge.md
WB_DBG_BRIDGE -- requirements
Module: wb_dbg_bridge

Interface
REQ-001 SHALL have parameter bus_timeout, default 1024: max cycles from stb assert to ack/err before abort.
REQ-002 SHALL have parameter rx_timeout, default 100000: max idle cycles between bytes of one command before discard.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  received byte, valid only when rx_valid=1.
REQ-006 rx_valid  in  1  one-cycle strobe, one byte per strobe; no backpressure.
REQ-007 tx_data  out  8  byte to send, held stable from tx_wr until the next tx_wr.
REQ-008 tx_wr  out  1  one-cycle strobe requesting transmission of tx_data.
REQ-009 tx_busy  in  1  transmitter busy; tx_wr SHALL NOT assert while 1.
REQ-010 wb_adr_o  out  32, wb_dat_o  out  32, wb_dat_i  in  32: Wishbone master address, write data, read data.
REQ-011 wb_sel_o  out  4 (always 4'hF), wb_we_o  out  1, wb_cyc_o  out  1, wb_stb_o  out  1, wb_ack_i  in  1, wb_err_i  in  1: Wishbone master control.

Function
REQ-012 Protocol: 0x57 'W' + 4 addr bytes + 4 data bytes, MSB first = write; 0x52 'R' + 4 addr bytes = read.
REQ-013 In IDLE, any byte other than 0x57/0x52 SHALL be ignored.
REQ-014 States: IDLE, ADDR, DATA, BUS, RESP, TXWAIT; 2-bit byte counter clears on entry to ADDR and DATA.
REQ-015 IDLE->ADDR on 0x57/0x52, latching we = (byte==0x57).
REQ-016 ADDR shifts bytes into address, MSB first; after 4th byte: ->DATA if write, ->BUS if read.
REQ-017 DATA shifts 4 bytes into write data, MSB first; ->BUS after 4th byte.
REQ-018 In ADDR/DATA, idle-cycle counter resets on each rx_valid; reaching rx_timeout SHALL discard the command and return to IDLE with no bus cycle and no reply.
REQ-019 BUS: cyc_o=stb_o=1 from the first BUS cycle, held until ack_i or err_i sampled 1 or timeout; both deassert the cycle after.
REQ-020 Read data SHALL be captured from wb_dat_i in the cycle ack_i=1.
REQ-021 ack_i and err_i both 1 in the same cycle SHALL be treated as err.
REQ-022 Timeout counter starts at 0 on BUS entry; if it reaches bus_timeout with no ack/err, drop cyc/stb and treat as err.
REQ-023 Reply on success: write = single 0x06; read = 4 data bytes, MSB first.
REQ-024 Reply on err/timeout: single 0x15, both commands.
REQ-025 RESP asserts tx_wr for one cycle when tx_busy=0, then enters TXWAIT.
REQ-026 TXWAIT waits one cycle, then for tx_busy=0: ->RESP if bytes remain, else ->IDLE.
REQ-027 rx_valid in BUS, RESP or TXWAIT SHALL be discarded.
REQ-028 wb_adr_o and wb_dat_o SHALL hold latched values from BUS entry through BUS exit.
REQ-029 Fixed latency: BUS->RESP in 1 cycle after ack; first tx_wr no earlier than 1 cycle after RESP entry.

Reset
REQ-030 While reset=1, state=IDLE; counters, address and data regs = 0; wb_cyc_o=wb_stb_o=wb_we_o=0; tx_wr=0; tx_data=0; wb_sel_o=4'hF.
REQ-031 Reset asserted mid-command or mid-bus-cycle SHALL drop cyc/stb immediately (asynchronously), abandon the partial command and send no reply.

Verification
REQ-032 Bytes 57 00 00 10 00 DE AD BE EF; ack after 2 cycles -> one write cycle: adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; then tx byte 0x06.
REQ-033 Bytes 52 70 00 00 04; slave acks with 0x12345678 -> read cycle, we=0; tx bytes 12,34,56,78 in order, each tx_wr only while tx_busy=0.
REQ-034 Read to address 0x50000000 with no ack (bus_timeout=16) -> cyc/stb drop after 16 cycles; tx 0x15 only.
REQ-035 Bytes 57 00 00 then silence for rx_timeout cycles, then 52 00 00 00 00 -> no bus cycle for the partial write; read proceeds normally.
REQ-036 Byte 0x41, then reset pulsed during a read BUS state with ack held 0 -> 0x41 ignored; cyc/stb low during reset; no tx_wr; next command accepted normally.
